// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down event/timer counter.
// Provides wrap or saturate at 0 / MAX_COUNT, synchronous clear and parallel
// load, a registered terminal-count pulse, a sticky overflow flag and a
// compare-match output.
// Optional feature macro: COUNTER_PRESCALE_EN. When it is defined, a step
// happens only once every PRESCALE enabled cycles. When it is undefined,
// every enabled cycle is a step.
module param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  // Reject configurations the counter cannot represent.
  if (WIDTH < 2) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be >= 2");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH-1) begin : g_bad_max
    $error("param_updown_counter: MAX_COUNT out of range");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be >= 1");
  end

  // A load value above the top of the range is clamped to MAX_COUNT.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // The current count sits on the boundary that a step in this direction would cross.
  function automatic logic at_bound(input logic [WIDTH-1:0] c, input logic up);
    return up ? (c == MAX_V) : (c == '0);
  endfunction

  // Next count for one step: either wrap to the other end or hold at the boundary.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] c, input logic up);
    if (at_bound(c, up)) begin
      if (SATURATE != 0) return c;
      else               return up ? '0 : MAX_V;
    end
    return up ? (c + WIDTH'(1)) : (c - WIDTH'(1));
  endfunction

  logic [WIDTH-1:0] cnt_p0, cnt_p1;
  logic             tc_p0, tc_p1;
  logic             ovf_p0, ovf_p1;
  logic             step_p0;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE-1);

  logic [PS_W-1:0] ps_p1;

  assign step_p0 = en && (ps_p1 == PS_LAST);

  // Prescaler: counts enabled cycles, restarts after each step, and is zeroed by clear and load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ps_p1 <= '0;
    else if (clr || load) ps_p1 <= '0;
    else if (en)          ps_p1 <= (ps_p1 == PS_LAST) ? '0 : (ps_p1 + PS_W'(1));
  end
`else
  assign step_p0 = en;
`endif

  // ---- stage p0: next-state selection (clr > load > step > hold) ----
  // Decide the next count, terminal-count pulse and overflow flag.
  always_comb begin
    cnt_p0 = cnt_p1;
    tc_p0  = 1'b0;
    ovf_p0 = ovf_p1;
    if (clr) begin
      cnt_p0 = '0;
      ovf_p0 = 1'b0;
    end else if (load) begin
      cnt_p0 = clamp_load(load_val);
    end else if (step_p0) begin
      cnt_p0 = step_val(cnt_p1, up_dn);
      if (at_bound(cnt_p1, up_dn)) begin
        tc_p0  = 1'b1;
        ovf_p0 = 1'b1;
      end
    end
  end

  // ---- stage p1: registered counter state ----
  // Capture the state. Reset clears it immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1 <= '0;
      tc_p1  <= 1'b0;
      ovf_p1 <= 1'b0;
    end else begin
      cnt_p1 <= cnt_p0;
      tc_p1  <= tc_p0;
      ovf_p1 <= ovf_p0;
    end
  end

  assign count = cnt_p1;
  assign tc    = tc_p1;
  assign ovf   = ovf_p1;
  assign match = (cnt_p1 == cmp_val);

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the fixed 8-bit enable/reset up-counter.
- Adds:
  - configurable width and modulus
  - up/down direction
  - synchronous clear and parallel load
  - wrap or saturate mode
  - registered terminal-count pulse and sticky overflow flag
  - compare-match output
- Used as a general event/timer counter and as the timebase for the team's sequential test structures.
- Clock and enable are ports, not internal generators.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_COUNT, 2**WIDTH-1, highest count value (1..2**WIDTH-1); range is 0..MAX_COUNT.
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.
- PRESCALE, 4, enabled cycles per step (>=1); used only with COUNTER_PRESCALE_EN.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load value.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- cmp_val  input  WIDTH  compare value.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- ovf  output  1  sticky overflow/underflow flag (registered).
- match  output  1  count == cmp_val (combinational from count register).

Behaviour:
- Reset (async, asserted): count=0, tc=0, ovf=0; prescaler=0. match follows count, so match=1 when cmp_val=0.
- Priority per rising edge: clr > load > en step > hold.
- clr: count=0, tc=0, ovf=0, prescaler=0.
- load: count=min(load_val, MAX_COUNT), tc=0, ovf unchanged, prescaler=0.
- Step condition: en=1 and no clr/load; with the optional prescaler, only on qualifying cycles.
- Up step:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT, SATURATE=0: count=0, tc=1, ovf=1.
  - count==MAX_COUNT, SATURATE=1: count holds MAX_COUNT, tc=1, ovf=1.
- Down step:
  - count>0: count-1.
  - count==0, SATURATE=0: count=MAX_COUNT, tc=1, ovf=1.
  - count==0, SATURATE=1: count holds 0, tc=1, ovf=1.
- tc:
  - High for exactly the cycle after a boundary step, coincident with the new count value.
  - In saturate mode, tc stays high every cycle while stepping continues to push against the boundary.
  - 0 on any non-boundary cycle.
- ovf: set by any boundary step; cleared only by reset or clr.
- en=0 (no clr/load): count and ovf hold, tc=0.
- up_dn may change on any cycle; it is sampled at the stepping edge, with no latency penalty.
- All arithmetic is modulo within 0..MAX_COUNT; count never exceeds MAX_COUNT.
- Latency: count updates one edge after the qualifying inputs; match is zero-cycle combinational from count.
- Reset mid-operation clears state immediately, independent of clk. The first step after deassertion starts from 0.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - Internal prescaler of width clog2(PRESCALE) counts enabled cycles.
  - A step occurs only on the enabled cycle where prescaler==PRESCALE-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - reset, clr and load zero the prescaler.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic; every enabled cycle is a step; PRESCALE is ignored.

Test Plan (WIDTH=4, MAX_COUNT=9 unless noted):
- Up wrap: reset, then en=1, up_dn=1 for 12 cycles -> count 1..9, 0, 1, 2; tc=1 only on the cycle count shows 0; ovf=1 from then on.
- Down saturate (SATURATE=1): load load_val=2, then en=1, up_dn=0 for 4 cycles -> count 1, 0, 0, 0; tc=1 on the last two cycles; ovf=1.
- Load clamp and priority: load=1, load_val=15, en=1 -> count=9. Next edge clr=1, load=1 -> count=0, ovf=0.
- Async reset mid-count: count=6, assert reset between edges -> count=0 immediately, before the next clk edge; tc=0, ovf=0.
- Match: cmp_val=5, counting up from 0 -> match=1 exactly while count=5. Then en=0 at count=5 -> count and match hold, tc=0.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=3): en=1 for 9 cycles -> count increments only on cycles 3, 6 and 9, reaching 3. Toggling en=0 for 2 cycles mid-sequence delays each subsequent increment by 2 cycles.
